nonrestoring_div_16bit: RTL and testbench

Sequential signed non-restoring divider: the inverse counterpart of the combinational Booth array multiplier. It divides a signed 16-bit dividend by a signed 16-bit divisor. It reuses the controlled add/subtract (CAS) step principle one row per clock instead of one row per array stage. The block sits beside the multiplier in the arithmetic datapath and uses a start/done handshake so the caller can overlap other work.

---
 rtl/div_pkg.sv | 16 +
 rtl/nr_div_step.sv | 23 ++
 rtl/nonrestoring_div_16bit.sv | 182 ++++++++++++++++++
 tb/tb_nonrestoring_div_16bit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // Most negative two's-complement value: 1 followed by DIV_WIDTH-1 zeros.
    localparam logic [DIV_WIDTH-1:0] DIV_NEG_LIMIT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nr_div_step.sv
// One controlled add/subtract row of a non-restoring divider (combinational).
module nr_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] m_ext;

    always_comb begin
        p_shift = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
        m_ext   = {1'b0, m_in};
        // The sign of P before the shift picks add or subtract.
        p_out   = p_in[WIDTH] ? (p_shift + m_ext) : (p_shift - m_ext);
        q_out   = {q_in[WIDTH-2:0], ~p_out[WIDTH]};
    end

endmodule

// File: rtl/nonrestoring_div_16bit.sv
// Sequential signed non-restoring divider: one CAS row per clock, start/done handshake.
module nonrestoring_div_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT  = CW'(WIDTH);
    localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state_q, state_d;

    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH:0]   step_p;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] rem_mag;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    nr_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in  (p_q),
        .q_in  (q_q),
        .m_in  (m_q),
        .p_out (step_p),
        .q_out (step_q)
    );

    // A new operation may begin from IDLE or from the DONE cycle.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (divisor == '0) ? DONE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == ITER) || (state_q == FIX);
        done = (state_q == DONE);
    end

    // The restored remainder lies in [0, M), so WIDTH-bit arithmetic is exact.
    assign rem_mag = p_q[WIDTH-1:0] + (p_q[WIDTH] ? m_q : '0);

    always_comb begin
        p_d         = p_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_d    = dividend[WIDTH-1];
                    ovf_pend_d = (dividend == NEG_LIMIT) && (divisor == '1);
                    ovf_d      = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        p_d         = '0;
                        q_d         = magnitude(dividend);
                        m_d         = magnitude(divisor);
                        cnt_d       = CNT_INIT;
                        quotient_d  = '0;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                    end
                end
            end
            ITER: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                // The minimum/-1 case wraps naturally: |q| = 2^(WIDTH-1), no negation.
                quotient_d  = q_neg_q ? (~q_q + 1'b1) : q_q;
                remainder_d = r_neg_q ? (~rem_mag + 1'b1) : rem_mag;
                ovf_d       = ovf_pend_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            p_q         <= p_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_nonrestoring_div_16bit.sv
// Self-checking bench for nonrestoring_div_16bit: vector table, protocol sequences, random ops.
module tb_nonrestoring_div_16bit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    nonrestoring_div_16bit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero with remainder following the dividend.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 16'hFFFF; r = a; dz = 1'b1; ov = 1'b0;
        end else begin
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            dz = 1'b0;
            ov = (sa == -32768) && (sb == -1);
        end
    endfunction

    // Drives start at a negedge and returns at the negedge where done is seen (start left low).
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int busy_cnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input int lat, input int busy_cnt);
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        model(a, b, eq, er, edz, eov);
        $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0b ov=%0b lat=%0d",
                 tag, $signed(a), $signed(b), $signed(quotient), $signed(remainder),
                 div_by_zero, overflow, lat);
        chk({tag, "_lat"},  32'(lat),        edz ? 32'd1 : 32'd18);
        chk({tag, "_busy"}, 32'(busy_cnt),   edz ? 32'd0 : 32'd17);
        chk({tag, "_q"},    32'(quotient),   32'(eq));
        chk({tag, "_r"},    32'(remainder),  32'(er));
        chk({tag, "_dz"},   32'(div_by_zero), 32'(edz));
        chk({tag, "_ov"},   32'(overflow),   32'(eov));
    endtask

    function automatic logic [15:0] rand_operand(input bit is_divisor);
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = DIV_NEG_LIMIT;
            1: v = 16'hFFFF;
            2: v = is_divisor ? 16'h0000 : 16'h7FFF;
            3, 4: begin
                v = 16'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) v = ~v + 16'd1;
            end
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        int bc;
        int extra;
        int gap;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;

        vecs[0] = '{16'd100,   16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 18};
        vecs[1] = '{16'hFF9C,  16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
        vecs[2] = '{16'd100,   16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0, 18};
        vecs[3] = '{16'hFF9C,  16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 1'b0, 18};
        vecs[4] = '{16'd7,     16'd100,  16'd0,    16'd7,    1'b0, 1'b0, 18};
        vecs[5] = '{16'd5,     16'd0,    16'hFFFF, 16'd5,    1'b1, 1'b0, 1};
        vecs[6] = '{16'h8000,  16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1, 18};
        vecs[7] = '{16'h8000,  16'd3,    16'hD556, 16'hFFFE, 1'b0, 1'b0, 18};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_q",    32'(quotient),    32'd0);
        chk("rst_r",    32'(remainder),   32'd0);
        chk("rst_busy", 32'(busy),        32'd0);
        chk("rst_done", 32'(done),        32'd0);
        chk("rst_dz",   32'(div_by_zero), 32'd0);
        chk("rst_ov",   32'(overflow),    32'd0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bc);
            $display("vec %0d: q=%0h r=%0h dz=%0b ov=%0b lat=%0d", i, quotient, remainder,
                     div_by_zero, overflow, lat);
            chk("vec_lat",  32'(lat),         32'(vecs[i].lat));
            chk("vec_busy", 32'(bc),          (vecs[i].lat == 1) ? 32'd0 : 32'd17);
            chk("vec_q",    32'(quotient),    32'(vecs[i].q));
            chk("vec_r",    32'(remainder),   32'(vecs[i].r));
            chk("vec_dz",   32'(div_by_zero), 32'(vecs[i].dz));
            chk("vec_ov",   32'(overflow),    32'(vecs[i].ov));
            @(negedge clk);
            chk("vec_hold_q", 32'(quotient), 32'(vecs[i].q));
            chk("vec_done_pulse", 32'(done), 32'd0);
        end

        // Back-to-back: start held in the DONE cycle
        run_div(16'd100, 16'd7, lat, bc);
        check_op("b2b_first", 16'd100, 16'd7, lat, bc);
        run_div(16'hFF9C, 16'd7, lat, bc);
        check_op("b2b_second", 16'hFF9C, 16'd7, lat, bc);
        @(negedge clk);

        // start pulsed at t+4 while busy must be ignored
        start = 1'b1; dividend = 16'd100; divisor = 16'd7; lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = (n == 4);
            if (n == 4) begin
                dividend = 16'd50;
                divisor  = 16'd5;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        $display("ignored-start: q=%0d r=%0d lat=%0d", $signed(quotient), $signed(remainder), lat);
        chk("ign_lat", 32'(lat),       32'd18);
        chk("ign_q",   32'(quotient),  32'd14);
        chk("ign_r",   32'(remainder), 32'd2);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ign_no_extra_done", 32'(extra),    32'd0);
        chk("ign_hold_q",        32'(quotient), 32'd14);

        // Reset at t+5 with start also high aborts the operation
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
        @(negedge clk);
        $display("abort: busy=%0b done=%0b q=%0h r=%0h", busy, done, quotient, remainder);
        chk("abort_busy", 32'(busy),        32'd0);
        chk("abort_done", 32'(done),        32'd0);
        chk("abort_q",    32'(quotient),    32'd0);
        chk("abort_r",    32'(remainder),   32'd0);
        chk("abort_dz",   32'(div_by_zero), 32'd0);
        rst = 1'b0; start = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("abort_quiet", 32'(extra), 32'd0);
        run_div(16'd100, 16'd7, lat, bc);
        check_op("after_abort", 16'd100, 16'd7, lat, bc);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            a = rand_operand(1'b0);
            b = rand_operand(1'b1);
            run_div(a, b, lat, bc);
            check_op($sformatf("rnd%0d", i), a, b, lat, bc);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                model(a, b, eq, er, edz, eov);
                chk("rnd_hold_q", 32'(quotient),  32'(eq));
                chk("rnd_hold_r", 32'(remainder), 32'(er));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
